rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_pkg.sv | 11 +
 rtl/wb_fifo.sv | 71 +++++++
 rtl/rf_writeback.sv | 104 ++++++++++
 tb/tb_rf_writeback.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path:
// default widths and the result-source encoding.
package rf_pkg;
    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_e;
endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: in-order {addr,data} entries with per-slot valid
// bits so the owner can see which registers have writes in flight.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [AW-1:0]            i_addr,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [AW-1:0]            o_addr,
    output logic [DW-1:0]            o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DEPTH-1:0]         o_vld,
    output logic [DEPTH*AW-1:0]      o_qaddr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (i_push) begin
                r_addr[r_wptr] <= i_addr;
                r_data[r_wptr] <= i_data;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Full push+pop hits the same slot: the set must win.
            r_vld <= (r_vld
                      & ~(DEPTH'(i_pop) << r_rptr))
                      | (DEPTH'(i_push) << r_wptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_addr  = r_addr[r_rptr];
    assign o_data  = r_data[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_vld   = r_vld;

    for (genvar g = 0; g < DEPTH; g++) begin : g_qa
        assign o_qaddr[g*AW +: AW] = r_addr[g];
    end
endmodule

// File: rtl/rf_writeback.sv
// Round-robin merge of ALU and load results into one register-file
// write port, with a queue, registered write outputs and busy mask.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_addr,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    input  logic                   wb_hold,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    output logic [2**AW-1:0]       pending_mask,
    output logic [$clog2(DEPTH):0] occupancy
);
    src_e              r_rr;
    logic              w_pop;
    logic              w_space;
    logic              w_acc_mem;
    logic              w_acc_alu;
    logic              w_push;
    logic [AW-1:0]     w_push_addr;
    logic [DW-1:0]     w_push_data;
    logic [AW-1:0]     w_head_addr;
    logic [DW-1:0]     w_head_data;
    logic              w_full;
    logic              w_empty;
    logic [DEPTH-1:0]  w_vld;
    logic [DEPTH*AW-1:0] w_qaddr;

    assign w_pop   = !w_empty && !wb_hold;
    assign w_space = !w_full || w_pop;

    assign mem_ready = !rst && w_space
                       && (!alu_valid || r_rr == SRC_MEM);
    assign alu_ready = !rst && w_space
                       && (!mem_valid || r_rr == SRC_ALU);

    assign w_acc_mem   = mem_valid && mem_ready;
    assign w_acc_alu   = alu_valid && alu_ready;
    assign w_push      = w_acc_mem || w_acc_alu;
    assign w_push_addr = w_acc_mem ? mem_addr : alu_addr;
    assign w_push_data = w_acc_mem ? mem_data : alu_data;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_addr  (w_push_addr),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_addr  (w_head_addr),
        .o_data  (w_head_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy),
        .o_vld   (w_vld),
        .o_qaddr (w_qaddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr     <= SRC_MEM;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (w_acc_mem) begin
                r_rr <= SRC_ALU;
            end else if (w_acc_alu) begin
                r_rr <= SRC_MEM;
            end
            rf_we <= w_pop;
            if (w_pop) begin
                rf_waddr <= w_head_addr;
                rf_wdata <= w_head_data;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i]) begin
                pending_mask[w_qaddr[i*AW +: AW]] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_rf_writeback;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic          wb_hold;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [15:0]   pending_mask;
    logic [2:0]    occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    ent_t          mq[$];
    bit            m_rr_alu;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    ent_t wlog[$];

    always #5 clk = ~clk;

    rf_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .wb_hold      (wb_hold),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask),
        .occupancy    (occupancy)
    );

    always @(negedge clk) begin
        if (rf_we === 1'b1) wlog.push_back('{rf_waddr, rf_wdata});
    end

    function automatic bit m_space();
        return (mq.size() < DEPTH) || (mq.size() > 0 && !wb_hold);
    endfunction

    function automatic bit m_mem_rdy();
        return !rst && m_space() && (!alu_valid || !m_rr_alu);
    endfunction

    function automatic bit m_alu_rdy();
        return !rst && m_space() && (!mem_valid || m_rr_alu);
    endfunction

    function automatic logic [15:0] m_pend();
        logic [15:0] m = '0;
        foreach (mq[k]) m[mq[k].a] = 1'b1;
        return m;
    endfunction

    // advance model by one clock using current inputs, then step DUT
    task automatic cycle();
        bit am, aa, pop;
        if (rst) begin
            mq.delete();
            m_rr_alu = 0;
            m_we = 0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            am  = mem_valid && m_mem_rdy();
            aa  = alu_valid && m_alu_rdy();
            pop = (mq.size() > 0) && !wb_hold;
            m_we = pop;
            if (pop) begin
                m_waddr = mq[0].a;
                m_wdata = mq[0].d;
                void'(mq.pop_front());
            end
            if (am) begin
                mq.push_back('{mem_addr, mem_data});
                m_rr_alu = 1;
            end else if (aa) begin
                mq.push_back('{alu_addr, alu_data});
                m_rr_alu = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0;
        mem_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        wb_hold = 0;
        alu_valid = 1;
        mem_valid = 1;
        alu_addr = 4'd1; alu_data = 8'h01;
        mem_addr = 4'd2; mem_data = 8'h02;
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_ready got=%b want=00",
                     {alu_ready, mem_ready});
        end
        cycle();
        cycle();
        n_chk++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL rst_out got=%b/%h/%h want=0/0/00",
                     rf_we, rf_waddr, rf_wdata);
        end
        n_chk++;
        if (occupancy !== 3'd0 || pending_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_occ got=%0d/%h want=0/0000",
                     occupancy, pending_mask);
        end
        rst = 0;
        idle();
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL post_rst_ready got=%b want=11",
                     {alu_ready, mem_ready});
        end
        cycle();
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_addr = 4'd3; alu_data = 8'h5A;
        #1;
        n_chk++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready got=%b want=1", alu_ready);
        end
        cycle();
        idle();
        n_chk++;
        if (pending_mask !== 16'h0008 || occupancy !== 3'd1
            || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c2 got=%h/%0d/%b want=0008/1/0",
                     pending_mask, occupancy, rf_we);
        end
        cycle();
        n_chk++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 8'h5A
            || pending_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL single_c3 got=%b/%h/%h/%h want=1/3/5a/0000",
                     rf_we, rf_waddr, rf_wdata, pending_mask);
        end
        cycle();
        n_chk++;
        if (rf_we !== 1'b0 || rf_waddr !== 4'd3 || rf_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_hold got=%b/%h/%h want=0/3/5a",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        ent_t want[4];
        want[0] = '{4'd1, 8'h11}; want[1] = '{4'd2, 8'h22};
        want[2] = '{4'd1, 8'h11}; want[3] = '{4'd2, 8'h22};
        rst = 1;
        cycle();
        rst = 0;
        wlog.delete();
        mem_addr = 4'd1; mem_data = 8'h11;
        alu_addr = 4'd2; alu_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1;
            alu_valid = 1;
            #1;
            n_chk++;
            if (mem_ready !== (i % 2 == 0) || alu_ready !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL cont_grant%0d got=%b%b want=%b%b", i,
                         mem_ready, alu_ready, i % 2 == 0, i % 2 == 1);
            end
            cycle();
        end
        idle();
        repeat (5) cycle();
        n_chk++;
        if (wlog.size() != 4) begin
            n_fail++;
            $display("FAIL cont_count got=%0d want=4", wlog.size());
        end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            n_chk++;
            if (wlog[k] !== want[k]) begin
                n_fail++;
                $display("FAIL cont_w%0d got=%h want=%h", k, wlog[k], want[k]);
            end
        end
    endtask

    task automatic test_full();
        wlog.delete();
        wb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1;
            mem_addr = AW'(4 + i);
            mem_data = DW'(8'h40 + i);
            #1;
            n_chk++;
            if (mem_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill%0d got=%b want=1", i, mem_ready);
            end
            cycle();
        end
        mem_addr = 4'd8; mem_data = 8'h44;
        alu_valid = 1; alu_addr = 4'd9; alu_data = 8'h99;
        #1;
        n_chk++;
        if ({mem_ready, alu_ready} !== 2'b00 || occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL full_block got=%b%b/%0d want=00/4",
                     mem_ready, alu_ready, occupancy);
        end
        cycle();
        alu_valid = 0;
        wb_hold = 0;
        #1;
        n_chk++;
        if (mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_release got=%b want=1", mem_ready);
        end
        cycle();
        idle();
        repeat (8) cycle();
        n_chk++;
        if (wlog.size() != 5) begin
            n_fail++;
            $display("FAIL full_count got=%0d want=5", wlog.size());
        end
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            n_chk++;
            if (wlog[k].a !== AW'(4 + k) || wlog[k].d !== DW'(8'h40 + k)) begin
                n_fail++;
                $display("FAIL full_w%0d got=%h/%h want=%h/%h", k,
                         wlog[k].a, wlog[k].d, AW'(4 + k), DW'(8'h40 + k));
            end
        end
    endtask

    task automatic test_ordering();
        wlog.delete();
        mem_valid = 1; mem_addr = 4'd7; mem_data = 8'h11;
        cycle();
        mem_valid = 0;
        alu_valid = 1; alu_addr = 4'd7; alu_data = 8'h22;
        #1;
        n_chk++;
        if (pending_mask[7] !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ord_b got=%b/%b want=1/1",
                     pending_mask[7], alu_ready);
        end
        cycle();
        idle();
        n_chk++;
        if (pending_mask[7] !== 1'b1 || rf_we !== 1'b1
            || rf_wdata !== 8'h11) begin
            n_fail++;
            $display("FAIL ord_c got=%b/%b/%h want=1/1/11",
                     pending_mask[7], rf_we, rf_wdata);
        end
        cycle();
        n_chk++;
        if (pending_mask[7] !== 1'b0 || rf_we !== 1'b1
            || rf_waddr !== 4'd7 || rf_wdata !== 8'h22) begin
            n_fail++;
            $display("FAIL ord_d got=%b/%b/%h/%h want=0/1/7/22",
                     pending_mask[7], rf_we, rf_waddr, rf_wdata);
        end
        cycle();
        n_chk++;
        if (wlog.size() != 2) begin
            n_fail++;
            $display("FAIL ord_count got=%0d want=2", wlog.size());
        end
    endtask

    task automatic test_reset_midop();
        wb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1;
            alu_addr = AW'(9 + i);
            alu_data = DW'($urandom);
            cycle();
        end
        idle();
        #1;
        n_chk++;
        if (occupancy !== 3'd3 || pending_mask !== 16'h0E00) begin
            n_fail++;
            $display("FAIL midop_fill got=%0d/%h want=3/0e00",
                     occupancy, pending_mask);
        end
        rst = 1;
        alu_valid = 1;
        cycle();
        rst = 0;
        idle();
        wb_hold = 0;
        wlog.delete();
        #1;
        n_chk++;
        if (occupancy !== 3'd0 || pending_mask !== 16'h0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_rst got=%0d/%h/%b want=0/0000/0",
                     occupancy, pending_mask, rf_we);
        end
        repeat (4) cycle();
        n_chk++;
        if (wlog.size() != 0) begin
            n_fail++;
            $display("FAIL midop_nowrite got=%0d want=0", wlog.size());
        end
    endtask

    task automatic test_wrap();
        ent_t exp_w[$];
        int acc = 0;
        int cyc = 0;
        wlog.delete();
        while (acc < 10 && cyc < 100) begin
            wb_hold = cyc[0];
            alu_valid = 1;
            alu_addr = AW'(acc);
            alu_data = DW'($urandom);
            #1;
            if (alu_ready === 1'b1) begin
                exp_w.push_back('{alu_addr, alu_data});
                acc++;
            end
            cycle();
            cyc++;
        end
        idle();
        wb_hold = 0;
        repeat (8) cycle();
        n_chk++;
        if (acc != 10 || wlog.size() != 10) begin
            n_fail++;
            $display("FAIL wrap_count got=%0d/%0d want=10/10",
                     acc, wlog.size());
        end
        for (int k = 0; k < exp_w.size() && k < wlog.size(); k++) begin
            n_chk++;
            if (wlog[k] !== exp_w[k]) begin
                n_fail++;
                $display("FAIL wrap_w%0d got=%h want=%h", k, wlog[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            wb_hold   = ($urandom_range(0, 2) == 0);
            alu_valid = $urandom_range(0, 1);
            mem_valid = $urandom_range(0, 1);
            alu_addr  = AW'($urandom);
            mem_addr  = AW'($urandom);
            alu_data  = DW'($urandom);
            mem_data  = DW'($urandom);
            #1;
            n_chk++;
            if (alu_ready !== m_alu_rdy() || mem_ready !== m_mem_rdy()) begin
                n_fail++;
                $display("FAIL rnd_ready c%0d got=%b%b want=%b%b", i,
                         alu_ready, mem_ready, m_alu_rdy(), m_mem_rdy());
            end
            n_chk++;
            if (occupancy !== 3'(mq.size()) || pending_mask !== m_pend()) begin
                n_fail++;
                $display("FAIL rnd_queue c%0d got=%0d/%h want=%0d/%h", i,
                         occupancy, pending_mask, mq.size(), m_pend());
            end
            n_chk++;
            if (rf_we !== m_we || rf_waddr !== m_waddr
                || rf_wdata !== m_wdata) begin
                n_fail++;
                $display("FAIL rnd_wr c%0d got=%b/%h/%h want=%b/%h/%h", i,
                         rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            cycle();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_full();
        test_ordering();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
